// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch-stage PC sequencer.
//               Holds the sequencer state encoding, the address width, the
//               default increment / reset vector and a target-alignment
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int ADDR_W = 16;

  // 16-bit instructions, byte addressed: sequential fetch steps by 2.
  localparam logic [ADDR_W-1:0] PC_INC_DEFAULT       = 16'd2;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

  // Instructions are halfword aligned, so bit0 of any redirect target is
  // dropped before it reaches the PC.
  function automatic logic [ADDR_W-1:0] align_target(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Bundle between the fetch-stage sequencer and its neighbours
//               (program counter, hazard unit, later pipeline stages, imem).
//               master : the pipeline side that raises requests and consumes
//                        the PC controls.
//               slave  : the pc_sequencer itself.
//   Requests  : pc_current, imem_ready, stall, branch_taken, branch_target,
//               jump, jump_target, halt, resume
//   Responses : pc_write, next_pc, if_flush, fetch_valid, halted, misalign,
//               stall_cycles
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc_current;
  logic              imem_ready;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              halt;
  logic              resume;

  logic              pc_write;
  logic [ADDR_W-1:0] next_pc;
  logic              if_flush;
  logic              fetch_valid;
  logic              halted;
  logic              misalign;
  logic [ADDR_W-1:0] stall_cycles;

  modport master (
    output pc_current, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, resume,
    input  pc_write, next_pc, if_flush, fetch_valid, halted, misalign,
           stall_cycles
  );

  modport slave (
    input  pc_current, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, halt, resume,
    output pc_write, next_pc, if_flush, fetch_valid, halted, misalign,
           stall_cycles
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low clear
//   en    - count this cycle
//   count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage controller driving PCWrite and the PC's next
//               address every cycle. Arbitrates sequential increment,
//               branch/jump redirects, hazard stalls, imem wait states and
//               halt/resume. A redirect that cannot be taken immediately is
//               parked in a pending register and replayed from PEND.
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - pc_sequencer_if.slave (requests in, PC controls and status out)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PC_INC       = PC_INC_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_misalign;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;

  logic              w_pc_write;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_if_flush;
  logic              w_fetch_valid;
  logic              w_pend_set;
  logic              w_pend_clr;
  logic              w_stall_inc;
  logic              w_misalign_next;
  logic [ADDR_W-1:0] w_stall_cycles;

  // Jump is the older/stronger request and wins over a same-cycle branch.
  assign w_redirect   = bus.jump | bus.branch_taken;
  assign w_target_raw = bus.jump ? bus.jump_target : bus.branch_target;
  assign w_target     = align_target(w_target_raw);
  assign w_pc_inc     = bus.pc_current + PC_INC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_BOOT;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_misalign <= w_misalign_next;
      if (w_pend_set) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
      end else if (w_pend_clr) begin
        r_pend_valid  <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_write      = 1'b0;
    w_next_pc       = w_pc_inc;
    w_if_flush      = 1'b0;
    w_fetch_valid   = 1'b0;
    w_pend_set      = 1'b0;
    w_pend_clr      = 1'b0;
    w_stall_inc     = 1'b0;
    w_misalign_next = 1'b0;

    unique case (r_state)
      ST_BOOT: begin
        w_pc_write   = 1'b1;
        w_next_pc    = RESET_VECTOR;
        w_state_next = ST_RUN;
      end

      ST_RUN: begin
        if (bus.halt) begin
          // A redirect arriving with halt is remembered so that resume
          // continues at the redirected address.
          w_state_next = ST_HALT;
          if (w_redirect) begin
            w_pend_set      = 1'b1;
            w_if_flush      = 1'b1;
            w_misalign_next = w_target_raw[0];
          end
        end else if (w_redirect && bus.imem_ready) begin
          w_pc_write      = 1'b1;
          w_next_pc       = w_target;
          w_if_flush      = 1'b1;
          w_misalign_next = w_target_raw[0];
        end else if (w_redirect) begin
          w_pend_set      = 1'b1;
          w_if_flush      = 1'b1;
          w_misalign_next = w_target_raw[0];
          w_state_next    = ST_PEND;
        end else if (bus.stall || !bus.imem_ready) begin
          w_stall_inc = 1'b1;
        end else begin
          w_pc_write    = 1'b1;
          w_fetch_valid = 1'b1;
        end
      end

      ST_PEND: begin
        // Younger instructions were already flushed when the redirect was
        // parked; only imem readiness matters here.
        if (bus.imem_ready) begin
          w_pc_write   = 1'b1;
          w_next_pc    = r_pend_target;
          w_pend_clr   = 1'b1;
          w_state_next = ST_RUN;
        end
      end

      ST_HALT: begin
        if (bus.resume) begin
          w_state_next = r_pend_valid ? ST_PEND : ST_RUN;
        end
      end

      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  sat_counter #(
    .WIDTH (ADDR_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (w_stall_inc),
    .count (w_stall_cycles)
  );

  assign bus.pc_write     = w_pc_write;
  assign bus.next_pc      = w_next_pc;
  assign bus.if_flush     = w_if_flush;
  assign bus.fetch_valid  = w_fetch_valid;
  assign bus.halted       = (r_state == ST_HALT);
  assign bus.misalign     = r_misalign;
  assign bus.stall_cycles = w_stall_cycles;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-stage controller that drives the program counter's write enable (PCWrite) and next-address input every cycle. It arbitrates sequential increment, branch/jump redirects from later stages, hazard stalls, instruction-memory wait states and halt/resume. It sits in IF beside the program counter and takes the PC's registered output back as pc_current.

Parameters:
PC_INC, 2, sequential increment added to pc_current (byte-addressed 16-bit instructions)
RESET_VECTOR, 16'h0000, address loaded into the PC in the BOOT cycle

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
pc_current  in  16  current PC (program counter output)
imem_ready  in  1  instruction memory can accept a fetch this cycle
stall  in  1  hazard-unit stall request
branch_taken  in  1  resolved taken branch
branch_target  in  16  branch destination
jump  in  1  jump request
jump_target  in  16  jump destination
halt  in  1  halt fetch request
resume  in  1  leave HALT
pc_write  out  1  PCWrite to program counter
next_pc  out  16  address_in to program counter
if_flush  out  1  squash the instruction currently in IF/ID
fetch_valid  out  1  fetch at pc_current this cycle is valid
halted  out  1  sequencer is in HALT
misalign  out  1  registered; high one cycle after an accepted redirect target with bit0=1
stall_cycles  out  16  saturating count of RUN cycles with pc_write=0

Behaviour:
- Reset (async, reset=0): state=BOOT; pend_valid=0; pend_target=0; stall_cycles=0; misalign=0. Combinational outputs take their BOOT values.
- pc_write, next_pc, if_flush and fetch_valid are combinational from state and inputs. The PC update lands at the next clk edge, giving 1-cycle redirect latency.
- Unless stated otherwise: next_pc=pc_current+PC_INC (mod 2^16, so 0xFFFE+2 -> 0x0000), pc_write=0, if_flush=0, fetch_valid=0.
- Redirect = jump|branch_taken. Target is jump_target if jump=1, else branch_target. Target bit0 is forced to 0.
- BOOT: pc_write=1, next_pc=RESET_VECTOR; all inputs ignored -> RUN.
- RUN, priority high to low:
  1. halt=1 -> HALT; pc_write=0. If a redirect is also present, capture its target into pend_target and set pend_valid=1; if_flush=1.
  2. Redirect, imem_ready=1 -> pc_write=1, next_pc=target, if_flush=1. Stay in RUN.
  3. Redirect, imem_ready=0 -> pend_target=target, pend_valid=1, if_flush=1, pc_write=0 -> PEND.
  4. stall=1 or imem_ready=0 -> pc_write=0; stall_cycles increments, saturating at 0xFFFF.
  5. Otherwise -> pc_write=1, next_pc=pc_current+PC_INC, fetch_valid=1.
- Redirect overrides stall in the same cycle.
- PEND:
  - New redirect, stall and halt inputs are ignored; the younger pipeline has already been flushed.
  - imem_ready=1 -> pc_write=1, next_pc=pend_target, pend_valid=0 -> RUN.
- HALT:
  - halted=1; pc_write=0; redirects ignored.
  - resume=1 -> PEND if pend_valid=1, else RUN. The transition takes effect next cycle.
- misalign is registered: high for exactly one cycle after any cycle in which a target with raw bit0=1 is accepted or captured.
- Simultaneous jump and branch_taken: jump wins.
- Async reset mid-PEND or mid-HALT drops the pending target.

Decomposition:
- Shared package fetch_pkg:
  - state enum (BOOT=2'd0, RUN=2'd1, PEND=2'd2, HALT=2'd3)
  - ADDR_W=16
  - PC_INC and RESET_VECTOR defaults
- Sub-module sat_counter (16-bit saturating increment, async active-low clear) for stall_cycles.
- Everything else is inline.

Test Plan:
- Release reset; pc_current=0x0000 -> BOOT cycle: pc_write=1, next_pc=0x0000. Next cycle RUN with imem_ready=1: next_pc=0x0002, fetch_valid=1.
- RUN, pc_current=0xFFFE, no events -> next_pc=0x0000, pc_write=1 (wrap).
- stall=1 for 3 cycles, then branch_taken=1 with branch_target=0x0041 while stall=1 -> pc_write=0 for 3 cycles and stall_cycles=3. Then pc_write=1, next_pc=0x0040, if_flush=1; misalign=1 on the following cycle.
- jump=1 (jump_target=0x1234) and branch_taken=1 (branch_target=0x2000), imem_ready=0 -> PEND, if_flush=1. Hold imem_ready=0 for 2 cycles with a new branch (0x3000) -> ignored. Then imem_ready=1 -> pc_write=1, next_pc=0x1234.
- halt=1 together with jump to 0x0100 -> HALT, halted=1, pc_write=0. resume=1 -> PEND; with imem_ready=1, next_pc=0x0100. Async reset asserted mid-PEND -> pend_valid cleared and state=BOOT.
- Force 70000 stall cycles -> stall_cycles saturates at 0xFFFF.
